// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
// Holds the FSM encoding and byte-lane/checksum rules.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam bit         MSB_FIRST   = 1'b1;
  localparam logic [7:0] CSUM_TARGET = 8'h00;

  function automatic logic st_rx_ready(state_t s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  endfunction

  function automatic logic st_busy(state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERROR});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port and status out.
// master drives the stream, slave is the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  Start;
  logic [7:0]            RxData;
  logic                  RxValid;
  logic                  RxReady;
  logic                  ImemWriteEn;
  logic [31:0]           ImemWriteAddr;
  logic [31:0]           ImemWriteData;
  logic                  CpuReset;
  logic                  Busy;
  logic                  Done;
  logic                  Error;
  logic [ADDR_WIDTH:0]   WordsLoaded;

  modport master (
    output Start, RxData, RxValid,
    input  RxReady, ImemWriteEn, ImemWriteAddr,
    input  ImemWriteData, CpuReset, Busy,
    input  Done, Error, WordsLoaded
  );

  modport slave (
    input  Start, RxData, RxValid,
    output RxReady, ImemWriteEn, ImemWriteAddr,
    output ImemWriteData, CpuReset, Busy,
    output Done, Error, WordsLoaded
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four accepted bytes into one 32-bit word.
// word_ready flags the byte that completes the word.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word
);
  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_load) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= MSB_FIRST ? {r_word[23:0], i_byte}
                          : {i_byte, r_word[31:8]};
    end
  end

  assign o_word_ready = i_load && (r_cnt == 2'd3);
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: LEN_HI LEN_LO data... CSUM.
// Keeps the CPU in reset until a load verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter bit HOLD_AT_BOOT = 1'b1
) (
  input logic          Clk,
  input logic          Reset,
  imem_loader_if.slave bus
);
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t r_state, w_next;

  logic                r_rx_ready, r_we, r_busy;
  logic                r_done, r_err, r_cpu_rst;
  logic [31:0]         r_waddr;
  logic [7:0]          r_len_hi, r_sum;
  logic [15:0]         r_len;
  logic [ADDR_WIDTH:0] r_idx, r_words;

  logic                w_xfer, w_start, w_word_ready;
  logic                w_last_word, w_len_over;
  logic [15:0]         w_len;
  logic [7:0]          w_sum_nxt;
  logic [ADDR_WIDTH:0] w_idx_nxt;
  logic [31:0]         w_word;

  assign w_xfer      = bus.RxValid && r_rx_ready;
  assign w_start     = bus.Start && !st_busy(r_state);
  assign w_len       = {r_len_hi, bus.RxData};
  assign w_len_over  = {1'b0, w_len} > CAP;
  assign w_sum_nxt   = r_sum + bus.RxData;
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last_word = 17'(w_idx_nxt) == {1'b0, r_len};

  loader_word_assembler u_asm (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_clear      (w_start),
    .i_load       (w_xfer && (r_state == S_DATA)),
    .i_byte       (bus.RxData),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR:
        if (bus.Start) w_next = S_LEN_HI;
      S_LEN_HI:
        if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO:
        if (w_xfer) begin
          if (w_len_over)         w_next = S_ERROR;
          else if (w_len == '0)   w_next = S_CSUM;
          else                    w_next = S_DATA;
        end
      S_DATA:
        if (w_word_ready) w_next = S_WRITE;
      S_WRITE:
        w_next = w_last_word ? S_CSUM : S_DATA;
      S_CSUM:
        if (w_xfer)
          w_next = (w_sum_nxt == CSUM_TARGET) ? S_DONE : S_ERROR;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rst  <= HOLD_AT_BOOT;
      r_waddr    <= '0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_words    <= '0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= st_rx_ready(w_next);
      r_busy     <= st_busy(w_next);
      r_we       <= (w_next == S_WRITE);
      if (w_xfer) r_sum <= w_sum_nxt;
      if (w_start) begin
        r_done    <= 1'b0;
        r_err     <= 1'b0;
        r_words   <= '0;
        r_idx     <= '0;
        r_sum     <= '0;
        r_cpu_rst <= 1'b1;
      end
      if (r_state == S_LEN_HI && w_xfer) r_len_hi <= bus.RxData;
      if (r_state == S_LEN_LO && w_xfer) r_len <= w_len;
      if (w_next == S_WRITE) r_waddr <= 32'({r_idx, 2'b00});
      if (r_state == S_WRITE) begin
        r_idx   <= w_idx_nxt;
        r_words <= r_words + 1'b1;
      end
      if (r_state == S_CSUM && w_next == S_DONE) begin
        r_done    <= 1'b1;
        r_cpu_rst <= 1'b0;
      end
      // CpuReset deliberately stays high on a failed load
      if ((r_state == S_LEN_LO || r_state == S_CSUM) &&
          w_next == S_ERROR)
        r_err <= 1'b1;
    end
  end

  assign bus.RxReady       = r_rx_ready;
  assign bus.ImemWriteEn   = r_we;
  assign bus.ImemWriteAddr = r_waddr;
  assign bus.ImemWriteData = w_word;
  assign bus.CpuReset      = r_cpu_rst;
  assign bus.Busy          = r_busy;
  assign bus.Done          = r_done;
  assign bus.Error         = r_err;
  assign bus.WordsLoaded   = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with immediate assertions.
// Write strobes are logged by a monitor and checked in sequence.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_wr  = 0;
  int   base;

  logic [31:0] wa [0:299];
  logic [31:0] wd [0:299];
  logic        wr_rdy [0:299];

  logic [7:0] fr_ok  [0:10];
  logic [7:0] fr_bad [0:10];

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(
    .ADDR_WIDTH   (8),
    .HOLD_AT_BOOT (1'b1)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ImemWriteEn === 1'b1) begin
      if (n_wr < 300) begin
        wa[n_wr]     = bus.ImemWriteAddr;
        wd[n_wr]     = bus.ImemWriteData;
        wr_rdy[n_wr] = bus.RxReady;
      end
      n_wr++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    while (bus.RxReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rx_accept_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    bus.RxValid = 1'b0;
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"}, 32'(n_wr - base), 32'd2);
    chk({tag, "_a0"}, wa[base], 32'h0);
    chk({tag, "_d0"}, wd[base], 32'h12345678);
    chk({tag, "_a1"}, wa[base+1], 32'h4);
    chk({tag, "_d1"}, wd[base+1], 32'h9ABCDEF0);
  endtask

  initial begin
    fr_ok = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC6};
    fr_bad = fr_ok;
    fr_bad[10] = 8'hC7;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.RxValid = 1'b0;
    bus.RxData = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_error", 32'(bus.Error), 32'd0);
    chk("rst_words", 32'(bus.WordsLoaded), 32'd0);
    chk("rst_cpurst", 32'(bus.CpuReset), 32'd1);
    chk("rst_rxready", 32'(bus.RxReady), 32'd0);
    chk("rst_we", 32'(bus.ImemWriteEn), 32'd0);
    chk("rst_waddr", bus.ImemWriteAddr, 32'd0);
    chk("rst_wdata", bus.ImemWriteData, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset lands mid-word: 5 of 8 data bytes sent
    base = n_wr;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(fr_ok[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.Busy), 32'd0);
    chk("mid_we", 32'(bus.ImemWriteEn), 32'd0);
    chk("mid_cpurst", 32'(bus.CpuReset), 32'd1);
    chk("mid_rxready", 32'(bus.RxReady), 32'd0);
    chk("mid_nwr", 32'(n_wr - base), 32'd1);
    chk("mid_a0", wa[base], 32'h0);
    chk("mid_d0", wd[base], 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    base = n_wr;
    pulse_start();
    chk("ok_busy_start", 32'(bus.Busy), 32'd1);
    chk("ok_cpurst_start", 32'(bus.CpuReset), 32'd1);
    for (int i = 0; i < 11; i++) send_byte(fr_ok[i], 1'b0);
    chk("ok_done", 32'(bus.Done), 32'd1);
    chk("ok_error", 32'(bus.Error), 32'd0);
    chk("ok_cpurst", 32'(bus.CpuReset), 32'd0);
    chk("ok_busy", 32'(bus.Busy), 32'd0);
    chk("ok_words", 32'(bus.WordsLoaded), 32'd2);
    check_two_words("ok");

    base = n_wr;
    pulse_start();
    chk("bad_done_clr", 32'(bus.Done), 32'd0);
    chk("bad_words_clr", 32'(bus.WordsLoaded), 32'd0);
    chk("bad_cpurst_start", 32'(bus.CpuReset), 32'd1);
    for (int i = 0; i < 11; i++) send_byte(fr_bad[i], 1'b0);
    chk("bad_error", 32'(bus.Error), 32'd1);
    chk("bad_done", 32'(bus.Done), 32'd0);
    chk("bad_cpurst", 32'(bus.CpuReset), 32'd1);
    chk("bad_words", 32'(bus.WordsLoaded), 32'd2);
    check_two_words("bad");

    // Length one past capacity
    base = n_wr;
    pulse_start();
    chk("ovf_error_clr", 32'(bus.Error), 32'd0);
    chk("ovf_busy_start", 32'(bus.Busy), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("ovf_error", 32'(bus.Error), 32'd1);
    chk("ovf_rxready", 32'(bus.RxReady), 32'd0);
    chk("ovf_busy", 32'(bus.Busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_rxready_later", 32'(bus.RxReady), 32'd0);
    chk("ovf_nwr", 32'(n_wr - base), 32'd0);

    base = n_wr;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("empty_done", 32'(bus.Done), 32'd1);
    chk("empty_words", 32'(bus.WordsLoaded), 32'd0);
    chk("empty_nwr", 32'(n_wr - base), 32'd0);

    // Gappy stream with a stray Start mid-load
    base = n_wr;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      if (i == 6) begin
        pulse_start();
        chk("gap_busy_after_start", 32'(bus.Busy), 32'd1);
      end
      send_byte(fr_ok[i], 1'b1);
    end
    chk("gap_done", 32'(bus.Done), 32'd1);
    chk("gap_words", 32'(bus.WordsLoaded), 32'd2);
    check_two_words("gap");
    chk("gap_rdy_w0", 32'(wr_rdy[base]), 32'd0);
    chk("gap_rdy_w1", 32'(wr_rdy[base+1]), 32'd0);

    // Full capacity: word i = {i,i,i,i}, checksum 0xFF
    base = n_wr;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) send_byte(8'(i), 1'b0);
    send_byte(8'hFF, 1'b0);
    chk("cap_done", 32'(bus.Done), 32'd1);
    chk("cap_words", 32'(bus.WordsLoaded), 32'd256);
    chk("cap_nwr", 32'(n_wr - base), 32'd256);
    chk("cap_a_last", wa[base+255], 32'h3FC);
    chk("cap_d_last", wd[base+255], 32'hFFFFFFFF);
    chk("cap_a_mid", wa[base+100], 32'h190);
    chk("cap_d_mid", wd[base+100], 32'h64646464);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
